// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multi-cycle control unit: opcodes, FSM states,
// datapath select values and the bundled control-output record.
package cpu_ctrl_pkg;

  // Major opcodes (instruction[6:0]) that the core executes.
  localparam logic [6:0] OP_LD  = 7'd3;
  localparam logic [6:0] OP_SD  = 7'd35;
  localparam logic [6:0] OP_R   = 7'd51;
  localparam logic [6:0] OP_BEQ = 7'd99;
  localparam logic [6:0] OP_JAL = 7'd111;

  // Sequencer states, one instruction at a time.
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_e;

  // ALU operation select.
  typedef enum logic [1:0] {
    ALU_ADD   = 2'd0,
    ALU_SUB   = 2'd1,
    ALU_FUNCT = 2'd2
  } alu_op_e;

  // PC source select.
  typedef enum logic [1:0] {
    PC_PLUS4  = 2'd0,
    PC_TARGET = 2'd1
  } pc_src_e;

  // Register-file write-back source select.
  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_MEM  = 2'd1,
    WB_PC4  = 2'd2
  } wb_sel_e;

  // Opcode classification produced by ctrl_opdecode.
  typedef struct packed {
    logic is_load;
    logic is_store;
    logic is_rtype;
    logic is_branch;
    logic is_jal;
    logic is_legal;
  } op_class_t;

  // Every per-cycle datapath control, bundled so the whole set can be
  // cleared in one assignment.
  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       mem_addr_sel;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       alu_src_b;
    logic [1:0] alu_op;
    logic       reg_write;
    logic [1:0] wb_sel;
  } ctrl_out_t;

  // True for states that talk to memory; the request handshake lives here.
  function automatic logic is_mem_state(input state_e s);
    return (s == S_FETCH) || (s == S_MEM);
  endfunction

endpackage

// File: rtl/ctrl_opdecode.sv
// Combinational opcode classifier: maps instruction[6:0] to class flags.
module ctrl_opdecode
  import cpu_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output op_class_t  op_class
);

  // Decode the major opcode into one-hot class flags plus a legality bit.
  always_comb begin
    // NOTE: every field gets a default before the case so no path leaves a
    // bit unassigned; a missing default here would infer a latch.
    op_class = '0;
    case (opcode)
      OP_LD:   op_class.is_load   = 1'b1;
      OP_SD:   op_class.is_store  = 1'b1;
      OP_R:    op_class.is_rtype  = 1'b1;
      OP_BEQ:  op_class.is_branch = 1'b1;
      OP_JAL:  op_class.is_jal    = 1'b1;
      default: op_class = '0;
    endcase
    op_class.is_legal = op_class.is_load | op_class.is_store |
                        op_class.is_rtype | op_class.is_branch |
                        op_class.is_jal;
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control unit: sequences one instruction through FETCH,
// DECODE, EXEC, MEM and WB, driving datapath enables and the memory
// request handshake. Unknown opcodes park the unit in TRAP until reset.
module multicycle_ctrl
  import cpu_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instruction,
  input  logic        mem_ready,
  input  logic        alu_zero,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_addr_sel,
  output logic        ir_write,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output logic        alu_src_b,
  output logic [1:0]  alu_op,
  output logic        reg_write,
  output logic [1:0]  wb_sel,
  output logic        illegal,
  output logic [63:0] instret
);

  state_e      state_q, state_d;
  logic [63:0] instret_q, instret_d;
  logic        illegal_q, illegal_d;
  logic        retire;
  op_class_t   op_class;
  ctrl_out_t   ctrl, ctrl_gated;

  // Only the opcode field is decoded here; the rest of the IR feeds immgen
  // and the register file directly.
  logic unused_instr_bits;
  assign unused_instr_bits = ^instruction[31:7];

  ctrl_opdecode u_opdecode (
    .opcode   (instruction[6:0]),
    .op_class (op_class)
  );

  // Next-state, retire and control decode from the current state and opcode.
  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    ctrl    = '0;
    case (state_q)
      S_FETCH: begin
        // Request stays up with stable qualifiers until memory answers.
        ctrl.mem_req      = 1'b1;
        ctrl.mem_addr_sel = 1'b0;
        if (mem_ready) begin
          ctrl.ir_write = 1'b1;
          ctrl.pc_write = 1'b1;
          ctrl.pc_src   = PC_PLUS4;
          state_d       = S_DECODE;
        end
      end

      S_DECODE: begin
        // No enables: immgen owns this cycle to register the immediate.
        state_d = op_class.is_legal ? S_EXEC : S_TRAP;
      end

      S_EXEC: begin
        if (op_class.is_load || op_class.is_store) begin
          ctrl.alu_src_b = 1'b1;
          ctrl.alu_op    = ALU_ADD;
          state_d        = S_MEM;
        end else if (op_class.is_rtype) begin
          ctrl.alu_src_b = 1'b0;
          ctrl.alu_op    = ALU_FUNCT;
          state_d        = S_WB;
        end else if (op_class.is_branch) begin
          ctrl.alu_op   = ALU_SUB;
          ctrl.pc_src   = PC_TARGET;
          ctrl.pc_write = alu_zero;
          state_d       = S_FETCH;
          retire        = 1'b1;
        end else if (op_class.is_jal) begin
          ctrl.reg_write = 1'b1;
          ctrl.wb_sel    = WB_PC4;
          ctrl.pc_write  = 1'b1;
          ctrl.pc_src    = PC_TARGET;
          state_d        = S_FETCH;
          retire         = 1'b1;
        end else begin
          // IR cannot change outside FETCH, so this is unreachable; trap
          // rather than run an unclassified instruction.
          state_d = S_TRAP;
        end
      end

      S_MEM: begin
        ctrl.mem_req      = 1'b1;
        ctrl.mem_addr_sel = 1'b1;
        ctrl.mem_we       = op_class.is_store;
        if (mem_ready) begin
          if (op_class.is_store) begin
            state_d = S_FETCH;
            retire  = 1'b1;
          end else begin
            state_d = S_WB;
          end
        end
      end

      S_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.wb_sel    = op_class.is_load ? WB_MEM : WB_ALU;
        state_d        = S_FETCH;
        retire         = 1'b1;
      end

      S_TRAP: begin
        // Terminal: every enable stays low until reset.
        state_d = S_TRAP;
      end

      default: begin
        state_d = S_FETCH;
      end
    endcase

    instret_d = instret_q + 64'(retire);
    illegal_d = illegal_q | (state_d == S_TRAP);
  end

  // Sequencer state, retired-instruction counter and sticky trap flag.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every flop
    // samples its pre-edge inputs regardless of statement order.
    if (rst) begin
      state_q   <= S_FETCH;
      instret_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
      illegal_q <= illegal_d;
    end
  end

  // Reset silences every output in the reset cycle itself, which also
  // aborts any memory request in flight.
  assign ctrl_gated = rst ? '0 : ctrl;

  assign mem_req      = ctrl_gated.mem_req;
  assign mem_we       = ctrl_gated.mem_we;
  assign mem_addr_sel = ctrl_gated.mem_addr_sel;
  assign ir_write     = ctrl_gated.ir_write;
  assign pc_write     = ctrl_gated.pc_write;
  assign pc_src       = ctrl_gated.pc_src;
  assign alu_src_b    = ctrl_gated.alu_src_b;
  assign alu_op       = ctrl_gated.alu_op;
  assign reg_write    = ctrl_gated.reg_write;
  assign wb_sel       = ctrl_gated.wb_sel;
  assign illegal      = illegal_q & ~rst;
  assign instret      = rst ? 64'd0 : instret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: a per-cycle vector table for the
// straight-line instruction mix, plus hand sequences for memory waits,
// reset during a pending access and the trap state.
module tb_multicycle_ctrl;
  import cpu_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instruction;
  logic        mem_ready;
  logic        alu_zero;
  logic        mem_req, mem_we, mem_addr_sel, ir_write, pc_write;
  logic [1:0]  pc_src, alu_op, wb_sel;
  logic        alu_src_b, reg_write, illegal;
  logic [63:0] instret;

  multicycle_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .instruction  (instruction),
    .mem_ready    (mem_ready),
    .alu_zero     (alu_zero),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr_sel (mem_addr_sel),
    .ir_write     (ir_write),
    .pc_write     (pc_write),
    .pc_src       (pc_src),
    .alu_src_b    (alu_src_b),
    .alu_op       (alu_op),
    .reg_write    (reg_write),
    .wb_sel       (wb_sel),
    .illegal      (illegal),
    .instret      (instret)
  );

  always #5 clk = ~clk;

  // Flattened view of the per-cycle outputs, excluding instret.
  typedef struct packed {
    logic       req;
    logic       we;
    logic       asel;
    logic       irw;
    logic       pcw;
    logic [1:0] pcs;
    logic       asb;
    logic [1:0] aop;
    logic       rw;
    logic [1:0] wbs;
    logic       ill;
  } outs_t;

  typedef struct {
    logic        rst;
    logic [31:0] instr;
    logic        rdy;
    logic        zero;
    state_e      st;
    outs_t       o;
    logic [63:0] ir;
  } vec_t;

  outs_t act;
  assign act = '{mem_req, mem_we, mem_addr_sel, ir_write, pc_write, pc_src,
                 alu_src_b, alu_op, reg_write, wb_sel, illegal};

  localparam logic [31:0] I_LD  = 32'h0000_3003;
  localparam logic [31:0] I_SD  = 32'h0000_3023;
  localparam logic [31:0] I_R   = 32'h0000_0033;
  localparam logic [31:0] I_BEQ = 32'h0000_0063;
  localparam logic [31:0] I_JAL = 32'h0000_006F;
  localparam logic [31:0] I_BAD = 32'h0000_007F;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic outs_t mk(input logic req, we, asel, irw, pcw,
                               input logic [1:0] pcs, input logic asb,
                               input logic [1:0] aop, input logic rw,
                               input logic [1:0] wbs, input logic ill);
    return '{req, we, asel, irw, pcw, pcs, asb, aop, rw, wbs, ill};
  endfunction

  function automatic vec_t v(input logic r, input logic [31:0] ins,
                             input logic rdy, z, input state_e st,
                             input outs_t o, input logic [63:0] n);
    return '{r, ins, rdy, z, st, o, n};
  endfunction

  // Drive one cycle of inputs, check on the falling edge, then advance.
  task automatic apply(input vec_t t, input string tag);
    rst         = t.rst;
    instruction = t.instr;
    mem_ready   = t.rdy;
    alu_zero    = t.zero;
    @(negedge clk);
    check({tag, " state"},   64'(dut.state_q), 64'(t.st));
    check({tag, " outs"},    64'(act),         64'(t.o));
    check({tag, " instret"}, instret,          t.ir);
    @(posedge clk);
    #1;
  endtask

  outs_t o_none, f_wait, f_go, ex_addr, mem_ld, mem_sd, wb_ld, wb_r;
  outs_t ex_jal, ex_beq_t, ex_beq_n, ex_r, o_trap;
  vec_t  tbl[$];

  initial begin
    //           req we as ir pw pcs  asb aop  rw wbs  ill
    o_none   = '0;
    f_wait   = mk(1, 0, 0, 0, 0, 2'd0, 0, 2'd0, 0, 2'd0, 0);
    f_go     = mk(1, 0, 0, 1, 1, 2'd0, 0, 2'd0, 0, 2'd0, 0);
    ex_addr  = mk(0, 0, 0, 0, 0, 2'd0, 1, 2'd0, 0, 2'd0, 0);
    mem_ld   = mk(1, 0, 1, 0, 0, 2'd0, 0, 2'd0, 0, 2'd0, 0);
    mem_sd   = mk(1, 1, 1, 0, 0, 2'd0, 0, 2'd0, 0, 2'd0, 0);
    wb_ld    = mk(0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 1, 2'd1, 0);
    wb_r     = mk(0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 1, 2'd0, 0);
    ex_jal   = mk(0, 0, 0, 0, 1, 2'd1, 0, 2'd0, 1, 2'd2, 0);
    ex_beq_t = mk(0, 0, 0, 0, 1, 2'd1, 0, 2'd1, 0, 2'd0, 0);
    ex_beq_n = mk(0, 0, 0, 0, 0, 2'd1, 0, 2'd1, 0, 2'd0, 0);
    ex_r     = mk(0, 0, 0, 0, 0, 2'd0, 0, 2'd2, 0, 2'd0, 0);
    o_trap   = mk(0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 0, 2'd0, 1);

    // ld, mem_ready high: 5 cycles, retires into WB->FETCH.
    tbl.push_back(v(0, I_LD,  1, 0, S_FETCH,  f_go,     0));
    tbl.push_back(v(0, I_LD,  1, 0, S_DECODE, o_none,   0));
    tbl.push_back(v(0, I_LD,  1, 0, S_EXEC,   ex_addr,  0));
    tbl.push_back(v(0, I_LD,  1, 0, S_MEM,    mem_ld,   0));
    tbl.push_back(v(0, I_LD,  1, 0, S_WB,     wb_ld,    0));
    // jal: 3 cycles.
    tbl.push_back(v(0, I_JAL, 1, 0, S_FETCH,  f_go,     1));
    tbl.push_back(v(0, I_JAL, 1, 0, S_DECODE, o_none,   1));
    tbl.push_back(v(0, I_JAL, 1, 0, S_EXEC,   ex_jal,   1));
    // beq taken.
    tbl.push_back(v(0, I_BEQ, 1, 1, S_FETCH,  f_go,     2));
    tbl.push_back(v(0, I_BEQ, 1, 1, S_DECODE, o_none,   2));
    tbl.push_back(v(0, I_BEQ, 1, 1, S_EXEC,   ex_beq_t, 2));
    // beq not taken, still retires.
    tbl.push_back(v(0, I_BEQ, 1, 0, S_FETCH,  f_go,     3));
    tbl.push_back(v(0, I_BEQ, 1, 0, S_DECODE, o_none,   3));
    tbl.push_back(v(0, I_BEQ, 1, 0, S_EXEC,   ex_beq_n, 3));
    // R-type with one fetch wait cycle.
    tbl.push_back(v(0, I_R,   0, 0, S_FETCH,  f_wait,   4));
    tbl.push_back(v(0, I_R,   1, 0, S_FETCH,  f_go,     4));
    tbl.push_back(v(0, I_R,   1, 0, S_DECODE, o_none,   4));
    tbl.push_back(v(0, I_R,   1, 0, S_EXEC,   ex_r,     4));
    tbl.push_back(v(0, I_R,   1, 0, S_WB,     wb_r,     4));

    // Reset: hold two edges; outputs silent and state FETCH after the first.
    rst         = 1'b1;
    instruction = I_LD;
    mem_ready   = 1'b0;
    alu_zero    = 1'b0;
    @(posedge clk);
    #1;
    apply(v(1, I_LD, 1, 0, S_FETCH, o_none, 0), "reset");

    foreach (tbl[i]) apply(tbl[i], $sformatf("row%0d", i));

    // sd with mem_ready held off for 3 MEM cycles: 7 cycles, no reg_write.
    apply(v(0, I_SD, 1, 0, S_FETCH,  f_go,    5), "sd fetch");
    apply(v(0, I_SD, 1, 0, S_DECODE, o_none,  5), "sd decode");
    apply(v(0, I_SD, 1, 0, S_EXEC,   ex_addr, 5), "sd exec");
    for (int i = 0; i < 4; i++)
      apply(v(0, I_SD, (i == 3), 0, S_MEM, mem_sd, 5),
            $sformatf("sd mem%0d", i));

    // ld aborted by reset while MEM waits; no retire.
    apply(v(0, I_LD, 1, 0, S_FETCH,  f_go,    6), "abort fetch");
    apply(v(0, I_LD, 1, 0, S_DECODE, o_none,  6), "abort decode");
    apply(v(0, I_LD, 1, 0, S_EXEC,   ex_addr, 6), "abort exec");
    apply(v(0, I_LD, 0, 0, S_MEM,    mem_ld,  6), "abort mem wait");
    apply(v(1, I_LD, 1, 0, S_MEM,    o_none,  0), "abort rst");
    apply(v(1, I_LD, 1, 0, S_FETCH,  o_none,  0), "abort rst fetch");
    apply(v(0, I_LD, 0, 0, S_FETCH,  f_wait,  0), "abort after");

    // jal to get a nonzero count, then an illegal opcode.
    apply(v(0, I_JAL, 1, 0, S_FETCH,  f_go,   0), "pre jal fetch");
    apply(v(0, I_JAL, 1, 0, S_DECODE, o_none, 0), "pre jal decode");
    apply(v(0, I_JAL, 1, 0, S_EXEC,   ex_jal, 0), "pre jal exec");
    apply(v(0, I_BAD, 1, 0, S_FETCH,  f_go,   1), "bad fetch");
    apply(v(0, I_BAD, 1, 0, S_DECODE, o_none, 1), "bad decode");
    for (int i = 0; i < 10; i++)
      apply(v(0, I_BAD, 1, 1, S_TRAP, o_trap, 1), $sformatf("trap%0d", i));
    apply(v(1, I_BAD, 1, 0, S_TRAP,  o_none, 0), "trap rst");
    apply(v(0, I_BAD, 0, 0, S_FETCH, f_wait, 0), "trap cleared");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle control unit for the 64-bit CPU core. Sequences one instruction at a time through fetch, decode, execute, memory and write-back, driving the PC, instruction register, register file, ALU and data memory enables, and the memory request handshake. Sits beside `immgen`, which registers its immediate on `clk` and is therefore given the full DECODE cycle. Supports opcodes 3 (ld), 35 (sd), 51 (R-type), 99 (beq) and 111 (jal); anything else traps.

## Interface

- No parameters. Opcode, state and select encodings are fixed in the package.
- `clk` in 1: single core clock; all state updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `instruction` in 32: current IR contents; only `[6:0]` is decoded here.
- `mem_ready` in 1: memory completion strobe; ignored while `mem_req`=0.
- `alu_zero` in 1: ALU zero flag, valid in EXEC.
- `mem_req` out 1: memory access request.
- `mem_we` out 1: write strobe, qualifies `mem_req`.
- `mem_addr_sel` out 1: memory address source, 0=PC, 1=ALU result.
- `ir_write` out 1: load IR from memory data.
- `pc_write` out 1: update PC.
- `pc_src` out 2: PC source, 0=PC+4, 1=oldPC+imm (branch or jal).
- `alu_src_b` out 1: ALU B operand, 0=rs2, 1=immediate.
- `alu_op` out 2: ALU operation, 0=add, 1=sub (compare), 2=funct-decoded.
- `reg_write` out 1: register-file write enable.
- `wb_sel` out 2: write-back source, 0=ALU, 1=memory data, 2=oldPC+4.
- `illegal` out 1: sticky trap flag.
- `instret` out 64: count of retired instructions.

## Operation

- State register with states FETCH, DECODE, EXEC, MEM, WB, TRAP. Outputs are Moore decodes of state plus opcode, except where a `mem_ready` qualifier is stated.
- FETCH: `mem_req`=1, `mem_addr_sel`=0, `mem_we`=0. On `mem_ready`=1: `ir_write`=1, `pc_write`=1, `pc_src`=0, go to DECODE. Otherwise hold.
- DECODE: all enables 0; `immgen` samples IR. Next state: EXEC for opcodes 3, 35, 51, 99, 111; otherwise TRAP.
- EXEC by opcode:
  - 3 and 35: `alu_src_b`=1, `alu_op`=0, go to MEM.
  - 51: `alu_src_b`=0, `alu_op`=2, go to WB.
  - 99: `alu_op`=1, `pc_src`=1, `pc_write`=`alu_zero`, go to FETCH (retire).
  - 111: `reg_write`=1, `wb_sel`=2, `pc_write`=1, `pc_src`=1, go to FETCH (retire).
- MEM: `mem_req`=1, `mem_addr_sel`=1, `mem_we`=1 for opcode 35. On `mem_ready`: opcode 35 goes to FETCH (retire), opcode 3 goes to WB.
- WB: `reg_write`=1; `wb_sel`=1 for opcode 3, 0 for opcode 51. Go to FETCH (retire).
- TRAP: terminal state. `illegal`=1 and all enables 0 until `rst`.
- `instret` increments by 1 on every retiring transition into FETCH and wraps modulo 2^64.

## Timing

- Reset: state=FETCH, `instret`=0, `illegal`=0. All other outputs are 0 during reset and in the reset cycle.
- Reset asserted mid-operation (including during a pending memory request) aborts the request. The next cycle is FETCH with no retire.
- `mem_req` holds high and its qualifiers stay stable until the cycle in which `mem_ready`=1. The transfer completes in that same cycle. A `mem_ready` arriving while `mem_req`=0 has no effect.
- Minimum latency with `mem_ready` tied high: ld 5 cycles, sd 4, R-type 4, beq 3, jal 3. Each wait cycle adds 1.
- `instruction` is sampled only in DECODE, EXEC, MEM and WB. The IR changes only in FETCH.

## Structure

- Package `cpu_ctrl_pkg` holds:
  - opcode constants (`OP_LD`=3, `OP_SD`=35, `OP_R`=51, `OP_BEQ`=99, `OP_JAL`=111);
  - the state enum;
  - the `alu_op`, `pc_src` and `wb_sel` encodings.
- One combinational sub-module, `ctrl_opdecode`, maps opcode to class flags (is_load, is_store, is_rtype, is_branch, is_jal, is_legal).

## Test plan

- Reset, then ld (`instruction`=0x00003003) with `mem_ready` held high. Required: states FETCH, DECODE, EXEC, MEM, WB; `reg_write`=1 with `wb_sel`=1 in WB; `instret`=1.
- sd (opcode 35) with `mem_ready` delayed 3 cycles in MEM. Required: `mem_req`/`mem_we`/`mem_addr_sel`=1/1/1 held for 4 cycles; `reg_write` never asserted; retires after 7 cycles.
- beq (opcode 99) run twice. With `alu_zero`=1: `pc_write`=1, `pc_src`=1 in EXEC. With `alu_zero`=0: `pc_write`=0. Both cases retire.
- jal (opcode 111). Required: in EXEC, `reg_write`=1, `wb_sel`=2, `pc_write`=1, `pc_src`=1; total 3 cycles.
- Opcode 0x7F. Required: DECODE goes to TRAP; `illegal`=1 held for 10 cycles; `instret` unchanged; `rst` returns to FETCH with `illegal`=0.
- Assert `rst` during the MEM wait of an ld. Required: next cycle FETCH, `mem_req`=0, `instret`=0.
